hdmi_rx_decoder: RTL and testbench

- Receive-side counterpart of the HDMI/DVI transmit path.
- Deserialises three SDR TMDS lanes (LSB first) in the bit-clock domain and finds the 10-bit word boundary from control tokens on the blue lane.
- TMDS-decodes each lane back to 8-bit RGB, blank, hsync and vsync, issuing a one-cycle pixel strobe per decoded word.
- Sits between the board-level TMDS input buffers and a capture/line-buffer block.

---
 rtl/hdmi_rx_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_hdmi_rx_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_rx_decoder.sv
// hdmi_rx_decoder: three-lane TMDS receiver. Deserialises the red, green and
// blue lanes in the bit-clock domain, aligns the 10-bit word boundary from
// blue-lane control tokens and decodes each word back to RGB/blank/sync.
//
// Optional feature macro: TMDS_ERR_CNT_EN adds out_err_count, a saturating
// count of locked boundaries where the lanes disagree on control/data status.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HUNT   | searching; every non-token boundary slips the phase one bit
// ST_CHECK  | token seen; counting consecutive tokens at this boundary
// ST_LOCKED | aligned; decoding words, watching for loss of tokens
module hdmi_rx_decoder #(
  parameter int LOCK_COUNT    = 4,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic        tmds_clk,
  input  logic        rst_n,
  input  logic        in_tmds_red,
  input  logic        in_tmds_green,
  input  logic        in_tmds_blue,
  output logic [7:0]  out_vga_red,
  output logic [7:0]  out_vga_green,
  output logic [7:0]  out_vga_blue,
  output logic        out_vga_blank,
  output logic        out_vga_hsync,
  output logic        out_vga_vsync,
  output logic        out_pixel_valid,
`ifdef TMDS_ERR_CNT_EN
  output logic [15:0] out_err_count,
`endif
  output logic        out_locked
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_WORDS + 1);
  localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_COUNT - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_WORDS - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  function automatic logic is_ctrl(input logic [9:0] q);
    return (q == TOK_00) || (q == TOK_01) || (q == TOK_10) || (q == TOK_11);
  endfunction

  // {c1,c0} of a control token; only meaningful when is_ctrl(q)
  function automatic logic [1:0] ctrl_key(input logic [9:0] q);
    logic [1:0] k;
    k = 2'b00;
    if (q == TOK_01) k = 2'b01;
    if (q == TOK_10) k = 2'b10;
    if (q == TOK_11) k = 2'b11;
    return k;
  endfunction

  function automatic logic [7:0] tmds_data(input logic [9:0] q);
    logic [7:0] dp;
    logic [7:0] d;
    dp   = q[9] ? ~q[7:0] : q[7:0];
    d    = 8'h00;
    d[0] = dp[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
    end
    return d;
  endfunction

  logic [9:0]    sr_r, sr_g, sr_b;
  logic [9:0]    word_r, word_g, word_b;
  logic          word_rdy;
  logic [3:0]    phase;
  logic [1:0]    state, state_nx;
  logic [CW-1:0] match_cnt, match_nx;
  logic [TW-1:0] to_cnt, to_nx;
  logic          slip;
  logic          strobe;
  logic          enter_hunt;
  logic          ctrl_r, ctrl_g, ctrl_b;
  logic [1:0]    key_b;

  assign ctrl_r = is_ctrl(word_r);
  assign ctrl_g = is_ctrl(word_g);
  assign ctrl_b = is_ctrl(word_b);
  assign key_b  = ctrl_key(word_b);
  assign out_locked = (state == ST_LOCKED);

  // Shift all lanes LSB first; capture the words at phase 9.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r     <= '0;
      sr_g     <= '0;
      sr_b     <= '0;
      word_r   <= '0;
      word_g   <= '0;
      word_b   <= '0;
      word_rdy <= 1'b0;
    end else begin
      sr_r     <= {in_tmds_red,   sr_r[9:1]};
      sr_g     <= {in_tmds_green, sr_g[9:1]};
      sr_b     <= {in_tmds_blue,  sr_b[9:1]};
      word_rdy <= (phase == 4'd9);
      if (phase == 4'd9) begin
        word_r <= {in_tmds_red,   sr_r[9:1]};
        word_g <= {in_tmds_green, sr_g[9:1]};
        word_b <= {in_tmds_blue,  sr_b[9:1]};
      end
    end
  end

  // Phase counter; a slip holds it at 0 one extra cycle (the evaluation
  // cycle always sits at phase 0).
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 4'd0;
    end else if (phase == 4'd9) begin
      phase <= 4'd0;
    end else if (!slip) begin
      phase <= phase + 4'd1;
    end
  end

  // Alignment FSM next-state, evaluated the cycle after each boundary.
  always_comb begin
    state_nx   = state;
    match_nx   = match_cnt;
    to_nx      = to_cnt;
    slip       = 1'b0;
    strobe     = 1'b0;
    enter_hunt = 1'b0;
    if (word_rdy) begin
      case (state)
        ST_HUNT: begin
          if (ctrl_b) begin
            state_nx = ST_CHECK;
            match_nx = CW'(1);
          end else begin
            slip = 1'b1;
          end
        end
        ST_CHECK: begin
          if (ctrl_b) begin
            if (match_cnt == LOCK_LAST) begin
              state_nx = ST_LOCKED;
              strobe   = 1'b1;
              to_nx    = '0;
            end else begin
              match_nx = match_cnt + CW'(1);
            end
          end else begin
            slip       = 1'b1;
            state_nx   = ST_HUNT;
            match_nx   = '0;
            enter_hunt = 1'b1;
          end
        end
        ST_LOCKED: begin
          strobe = 1'b1;
          if (ctrl_b) begin
            to_nx = '0;
          end else if (to_cnt == TIMEOUT_LAST) begin
            state_nx   = ST_HUNT;
            to_nx      = '0;
            match_nx   = '0;
            enter_hunt = 1'b1;
          end else begin
            to_nx = to_cnt + TW'(1);
          end
        end
        default: begin
          state_nx   = ST_HUNT;
          match_nx   = '0;
          to_nx      = '0;
          enter_hunt = 1'b1;
        end
      endcase
    end
  end

  // FSM state and counters.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      match_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      to_cnt    <= to_nx;
    end
  end

  // Decoded outputs; updated only on a strobe, held otherwise.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vga_red     <= 8'h00;
      out_vga_green   <= 8'h00;
      out_vga_blue    <= 8'h00;
      out_vga_blank   <= 1'b1;
      out_vga_hsync   <= 1'b0;
      out_vga_vsync   <= 1'b0;
      out_pixel_valid <= 1'b0;
    end else begin
      out_pixel_valid <= strobe;
      if (strobe) begin
        if (ctrl_b) begin
          out_vga_red   <= 8'h00;
          out_vga_green <= 8'h00;
          out_vga_blue  <= 8'h00;
          out_vga_blank <= 1'b1;
          out_vga_hsync <= key_b[0];
          out_vga_vsync <= key_b[1];
        end else begin
          out_vga_red   <= tmds_data(word_r);
          out_vga_green <= tmds_data(word_g);
          out_vga_blue  <= tmds_data(word_b);
          out_vga_blank <= 1'b0;
        end
      end
    end
  end

`ifdef TMDS_ERR_CNT_EN
  // Lane-disagreement counter; saturates, cleared on every return to hunt.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_count <= 16'h0000;
    end else if (enter_hunt) begin
      out_err_count <= 16'h0000;
    end else if (word_rdy && (state == ST_LOCKED) &&
                 ((ctrl_b != ctrl_r) || (ctrl_b != ctrl_g)) &&
                 (out_err_count != 16'hFFFF)) begin
      out_err_count <= out_err_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_rx_decoder.sv
// tb_hdmi_rx_decoder: directed bench for hdmi_rx_decoder (TIMEOUT_WORDS = 8).
// Honours TMDS_ERR_CNT_EN when the design is built with it.
module tb_hdmi_rx_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef struct packed {
    int       gen;
    int       cyc;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic     blank;
    logic     hs;
    logic     vs;
  } cap_t;

  logic       tmds_clk;
  logic       rst_n;
  logic       in_r, in_g, in_b;
  logic [7:0] o_r, o_g, o_b;
  logic       o_blank, o_hs, o_vs, o_valid, o_locked;
`ifdef TMDS_ERR_CNT_EN
  logic [15:0] o_err;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   gen    = 0;
  int   cyc;
  int   rise_cyc = -1;
  logic locked_d = 1'b0;
  cap_t caps[$];

  hdmi_rx_decoder #(.LOCK_COUNT(4), .TIMEOUT_WORDS(8)) dut (
    .tmds_clk       (tmds_clk),
    .rst_n          (rst_n),
    .in_tmds_red    (in_r),
    .in_tmds_green  (in_g),
    .in_tmds_blue   (in_b),
    .out_vga_red    (o_r),
    .out_vga_green  (o_g),
    .out_vga_blue   (o_b),
    .out_vga_blank  (o_blank),
    .out_vga_hsync  (o_hs),
    .out_vga_vsync  (o_vs),
    .out_pixel_valid(o_valid),
`ifdef TMDS_ERR_CNT_EN
    .out_err_count  (o_err),
`endif
    .out_locked     (o_locked)
  );

  initial tmds_clk = 1'b0;
  always #5 tmds_clk = ~tmds_clk;

  // Cycle index: equals k at the negedge following the k-th edge after reset.
  always @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record every strobe and the cycle at which lock rises.
  always @(negedge tmds_clk) begin
    if (!rst_n) begin
      locked_d = 1'b0;
    end else begin
      if (o_valid) begin
        cap_t c;
        c.gen = gen; c.cyc = cyc; c.r = o_r; c.g = o_g; c.b = o_b;
        c.blank = o_blank; c.hs = o_hs; c.vs = o_vs;
        caps.push_back(c);
      end
      if (o_locked && !locked_d) rise_cyc = cyc;
      locked_d = o_locked;
    end
  end

  // Reference TMDS encoder at zero running disparity.
  function automatic logic [9:0] tmds_encode(input logic [7:0] d);
    logic [8:0] qm;
    int n1;
    n1 = $countones(d);
    qm = 9'h000;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
  endfunction

  function automatic bit find_cap(input int c, output cap_t r);
    r = '0;
    foreach (caps[i]) begin
      if (caps[i].gen == gen && caps[i].cyc == c) begin
        r = caps[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cap(input string tag, input int c, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b,
                           input logic bl, input logic hs, input logic vs);
    cap_t cp;
    bit   f;
    f = find_cap(c, cp);
    check({tag, "_strobe"}, 32'(f), 32'd1);
    check({tag, "_red"},   32'(cp.r), 32'(r));
    check({tag, "_green"}, 32'(cp.g), 32'(g));
    check({tag, "_blue"},  32'(cp.b), 32'(b));
    check({tag, "_blank"}, 32'(cp.blank), 32'(bl));
    check({tag, "_hsync"}, 32'(cp.hs), 32'(hs));
    check({tag, "_vsync"}, 32'(cp.vs), 32'(vs));
  endtask

  task automatic check_no_cap(input string tag, input int c);
    cap_t cp;
    bit   f;
    f = find_cap(c, cp);
    check(tag, 32'(f), 32'd0);
  endtask

  task automatic send_bits(input logic [9:0] r, input logic [9:0] g,
                           input logic [9:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      in_r = r[i]; in_g = g[i]; in_b = b[i];
      @(negedge tmds_clk);
    end
  endtask

  task automatic send_word(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    send_bits(r, g, b, 10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_r = 1'b0; in_g = 1'b0; in_b = 1'b0;
    gen++;
    repeat (2) @(negedge tmds_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] ea5, e3c, eff, e10, e81, e00, d1, d2, d3;
    ea5 = tmds_encode(8'hA5); e3c = tmds_encode(8'h3C); eff = tmds_encode(8'hFF);
    e10 = tmds_encode(8'h10); e81 = tmds_encode(8'h81); e00 = tmds_encode(8'h00);
    d1  = tmds_encode(8'h12); d2  = tmds_encode(8'h34); d3  = tmds_encode(8'h56);

    // Aligned stream from reset: word k boundary at edge 10k, strobe at 10k+1.
    do_reset();
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_blank",  32'(o_blank),  32'd1);
    check("rst_valid",  32'(o_valid),  32'd0);
    check("rst_rgb",    {8'h0, o_r, o_g, o_b}, 32'd0);
    check("rst_sync",   {30'd0, o_vs, o_hs}, 32'd0);
    repeat (4) send_word(T00, T00, T00);
    check("lock_before_4th_eval", 32'(o_locked), 32'd0);
    send_word(T00, T00, T00);
    check("lock_after_4", 32'(o_locked), 32'd1);
    check("lock_rise_cyc", 32'(rise_cyc), 32'd41);
    check_no_cap("no_strobe_pre_lock", 31);
    check_cap("first_valid", 41, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // Sync tokens, then data words with hsync/vsync held.
    send_word(T00, T00, T01);   // word 6
    send_word(T00, T00, T10);   // word 7
    send_word(T00, T00, T11);   // word 8
    send_word(ea5, e3c, eff);   // word 9
    send_word(e10, e81, e00);   // word 10
    send_word(T00, T00, T00);   // word 11
    check_cap("hsync_tok", 61, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    check_no_cap("strobe_width_61", 62);
    check_cap("vsync_tok", 71, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    check_no_cap("strobe_width_71", 72);
    check_cap("both_tok", 81, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    check_cap("data_a5_3c_ff", 91, 8'hA5, 8'h3C, 8'hFF, 1'b0, 1'b1, 1'b1);
    check_cap("data_10_81_00", 101, 8'h10, 8'h81, 8'h00, 1'b0, 1'b1, 1'b1);

    // Timeout: 8 data words drop lock after the 8th boundary.
    repeat (8) send_word(d1, d2, d3);   // words 12..19
    check("lock_before_timeout", 32'(o_locked), 32'd1);
    send_word(T00, T00, T00);           // word 20
    check("lock_dropped", 32'(o_locked), 32'd0);
    repeat (3) send_word(T00, T00, T00); // words 21..23, relock at 231
    repeat (7) send_word(d1, d2, d3);   // words 24..30
    check("relock_rise_cyc", 32'(rise_cyc), 32'd231);
    check("relock_hold_7", 32'(o_locked), 32'd1);
    send_word(T00, T00, T00);           // word 31 clears the timeout
    repeat (7) send_word(d1, d2, d3);   // words 32..38
    send_word(T00, T00, T00);           // word 39
    check("lock_retained", 32'(o_locked), 32'd1);

    // Asynchronous reset in the middle of a word.
    send_word(ea5, e3c, eff);           // word 40, strobe at 401
    send_bits(T00, T00, T00, 5);
    check("pre_rst_red", 32'(o_r), 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_locked", 32'(o_locked), 32'd0);
    check("mid_rst_blank",  32'(o_blank),  32'd1);
    check("mid_rst_rgb",    {8'h0, o_r, o_g, o_b}, 32'd0);
    check("mid_rst_valid",  32'(o_valid),  32'd0);

    // 3-bit offset: boundaries 10, 21, 32 slip; tokens aligned at 43..73.
    do_reset();
    send_bits(10'h000, 10'h000, 10'h000, 3);
    repeat (8) send_word(T00, T00, T00);
    check("offs_locked", 32'(o_locked), 32'd1);
    check("offs_rise_cyc", 32'(rise_cyc), 32'd74);
    check_no_cap("offs_no_early", 64);
    check_cap("offs_first_valid", 74, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

`ifdef TMDS_ERR_CNT_EN
    do_reset();
    check("err_rst", 32'(o_err), 32'd0);
    repeat (4) send_word(T00, T00, T00);
    repeat (3) send_word(T00, e3c, T00);
    send_word(T00, T00, T00);
    check("err_locked", 32'(o_locked), 32'd1);
    check("err_count_3", 32'(o_err), 32'd3);
    send_bits(T00, T00, T00, 4);
    #2 rst_n = 1'b0;
    #1;
    check("err_mid_rst_count", 32'(o_err), 32'd0);
    check("err_mid_rst_locked", 32'(o_locked), 32'd0);
    check("err_mid_rst_blank", 32'(o_blank), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
